// File: rtl/uart_csr_bridge_if.sv
// Byte-stream (uart_transceiver) and CSR bus signals seen by the UART-to-CSR bridge.
// The master modport is the bridge; the slave modport is the transceiver/CSR side.
interface uart_csr_bridge_if;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_done;
   logic [13:0] csr_a;
   logic        csr_we;
   logic [31:0] csr_di;
   logic [31:0] csr_do;

   modport master (
      input  rx_data, rx_done, tx_done, csr_do,
      output tx_data, tx_wr, csr_a, csr_we, csr_di
   );

   modport slave (
      output rx_data, rx_done, tx_done, csr_do,
      input  tx_data, tx_wr, csr_a, csr_we, csr_di
   );
endinterface

// File: rtl/uart_csr_bridge.sv
// UART-driven CSR bus master: decodes CMD/ADDR[/DATA] byte frames, performs one CSR
// access and answers with an ack byte (write) or four data bytes MSB first (read).
module uart_csr_bridge #(
   parameter logic [31:0] timeout  = 32'd10000000,
   parameter logic [7:0]  ack_byte = 8'hAA
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   uart_csr_bridge_if.master       bus,
   output logic                    busy
);

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_DATA,
      S_ISSUE_WR,
      S_ISSUE_RD,
      S_CAPTURE,
      S_TX_SEND,
      S_TX_WAIT
   } state_t;

   state_t      state;
   logic        is_write;
   logic [5:0]  addr_hi;
   logic [7:0]  addr_lo;
   logic [23:0] wr_data;
   logic [1:0]  rx_cnt;
   logic [31:0] tmo_cnt;
   logic [31:0] tx_shift;
   logic [2:0]  tx_cnt;
   logic        rx_state;

   assign rx_state = (state == S_ADDR_HI) || (state == S_ADDR_LO) || (state == S_DATA);
   assign busy     = (state != S_IDLE);

   // NOTE: every register here is updated with <= so all branches see pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= S_IDLE;
         is_write    <= 1'b0;
         addr_hi     <= '0;
         addr_lo     <= '0;
         wr_data     <= '0;
         rx_cnt      <= '0;
         tmo_cnt     <= '0;
         tx_shift    <= '0;
         tx_cnt      <= '0;
         bus.csr_a   <= '0;
         bus.csr_we  <= 1'b0;
         bus.csr_di  <= '0;
         bus.tx_data <= '0;
         bus.tx_wr   <= 1'b0;
      end else begin
         bus.csr_we <= 1'b0;
         bus.tx_wr  <= 1'b0;

         // Inter-byte timeout; an rx_done in the expiry cycle still wins below.
         if (rx_state && !bus.rx_done) begin
            if (tmo_cnt == 32'd0) state <= S_IDLE;
            else                  tmo_cnt <= tmo_cnt - 32'd1;
         end

         case (state)
            S_IDLE: begin
               if (bus.rx_done && (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ)) begin
                  is_write <= (bus.rx_data == CMD_WRITE);
                  tmo_cnt  <= timeout;
                  state    <= S_ADDR_HI;
               end
            end
            S_ADDR_HI: begin
               if (bus.rx_done) begin
                  addr_hi <= bus.rx_data[5:0];
                  tmo_cnt <= timeout;
                  state   <= S_ADDR_LO;
               end
            end
            S_ADDR_LO: begin
               if (bus.rx_done) begin
                  tmo_cnt <= timeout;
                  if (is_write) begin
                     addr_lo <= bus.rx_data;
                     rx_cnt  <= '0;
                     state   <= S_DATA;
                  end else begin
                     bus.csr_a <= {addr_hi, bus.rx_data};
                     state     <= S_ISSUE_RD;
                  end
               end
            end
            S_DATA: begin
               if (bus.rx_done) begin
                  tmo_cnt <= timeout;
                  if (rx_cnt == 2'd3) begin
                     // Address and data are committed together so a timed-out frame leaves them untouched.
                     bus.csr_a  <= {addr_hi, addr_lo};
                     bus.csr_di <= {wr_data, bus.rx_data};
                     bus.csr_we <= 1'b1;
                     state      <= S_ISSUE_WR;
                  end else begin
                     wr_data <= {wr_data[15:0], bus.rx_data};
                     rx_cnt  <= rx_cnt + 2'd1;
                  end
               end
            end
            S_ISSUE_WR: begin
               bus.tx_data <= ack_byte;
               bus.tx_wr   <= 1'b1;
               tx_cnt      <= 3'd1;
               state       <= S_TX_SEND;
            end
            S_ISSUE_RD: begin
               state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               tx_shift    <= bus.csr_do;
               bus.tx_data <= bus.csr_do[31:24];
               bus.tx_wr   <= 1'b1;
               tx_cnt      <= 3'd4;
               state       <= S_TX_SEND;
            end
            S_TX_SEND: begin
               state <= S_TX_WAIT;
            end
            S_TX_WAIT: begin
               if (bus.tx_done) begin
                  if (tx_cnt == 3'd1) begin
                     tx_cnt <= '0;
                     state  <= S_IDLE;
                  end else begin
                     tx_cnt      <= tx_cnt - 3'd1;
                     tx_shift    <= tx_shift << 8;
                     bus.tx_data <= tx_shift[23:16];
                     bus.tx_wr   <= 1'b1;
                     state       <= S_TX_SEND;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
